// File: rtl/ahb_sram_slave_p_pkg.sv
// Shared AHB-Lite encodings and the SRAM slave FSM state type.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY    = 2'b00;
  localparam logic [1:0] HRESP_ERROR   = 2'b01;

  localparam logic [2:0] HSIZE_BYTE    = 3'b000;
  localparam logic [2:0] HSIZE_HALF    = 3'b001;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic [2:0] HSIZE_DWORD   = 3'b011;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RWAIT = 2'd1,
    ST_ERR1  = 2'd2,
    ST_ERR2  = 2'd3
  } ahb_state_e;

endpackage

// File: rtl/ahb_sram_array.sv
// Word-organised SRAM: one synchronous write port with per-byte enables,
// one asynchronous read port. Contents are never reset.
module ahb_sram_array #(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 16384,
  parameter int AW         = 14
) (
  input  logic                    i_clk,
  input  logic                    i_we,
  input  logic [AW-1:0]           i_waddr,
  input  logic [DATA_WIDTH/8-1:0] i_wstrb,
  input  logic [DATA_WIDTH-1:0]   i_wdata,
  input  logic [AW-1:0]           i_raddr,
  output logic [DATA_WIDTH-1:0]   o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

  // Byte-lane write port
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      for (int b = 0; b < DATA_WIDTH/8; b++) begin
        if (i_wstrb[b]) begin
          r_mem[i_waddr][8*b +: 8] <= i_wdata[8*b +: 8];
        end
      end
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/ahb_sram_slave_p.sv
// Parametrised AHB-Lite SRAM slave with configurable width, depth, read wait
// states and a two-cycle ERROR response for illegal transfers.
module ahb_sram_slave_p
  import ahb_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 16384,
  parameter int RD_WAIT    = 1
) (
  input  logic                  hclk,
  input  logic                  hreset,
  input  logic                  hsel_i,
  input  logic                  hready_i,
  input  logic [1:0]            htrans_i,
  input  logic [2:0]            hsize_i,
  input  logic                  hwrite_i,
  input  logic [ADDR_WIDTH-1:0] haddr_i,
  input  logic [DATA_WIDTH-1:0] hwdata_i,
  output logic                  hready_o,
  output logic [1:0]            hresp_o,
  output logic [DATA_WIDTH-1:0] hrdata_o
);

  localparam int NB     = DATA_WIDTH / 8;
  localparam int LANE_W = $clog2(NB);
  localparam int IDX_W  = ADDR_WIDTH - LANE_W;
  localparam int MEM_AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  function automatic logic is_legal(input logic [2:0] size,
                                    input logic [LANE_W-1:0] off,
                                    input logic [IDX_W-1:0] idx);
    logic [7:0] mask;
    mask = (8'd1 << size) - 8'd1;
    return (size <= 3'(LANE_W)) &&
           ((off & mask[LANE_W-1:0]) == '0) &&
           ({1'b0, idx} < (IDX_W+1)'(MEM_DEPTH));
  endfunction

  function automatic logic [NB-1:0] lane_strobe(input logic [2:0] size,
                                                input logic [LANE_W-1:0] off);
    logic [NB-1:0] base;
    base = NB'((16'd1 << (16'd1 << size)) - 16'd1);
    return base << off;
  endfunction

  ahb_state_e            r_state;
  logic [2:0]            r_cnt;
  logic                  r_wr_pend;
  logic [IDX_W-1:0]      r_idx;
  logic [NB-1:0]         r_strb;
  logic                  r_hready;
  logic [1:0]            r_hresp;
  logic [DATA_WIDTH-1:0] r_hrdata;

  logic                  w_accept;
  logic [IDX_W-1:0]      w_idx;
  logic [LANE_W-1:0]     w_off;
  logic                  w_legal;
  logic [NB-1:0]         w_strb;
  logic [MEM_AW-1:0]     w_rd_idx;
  logic [DATA_WIDTH-1:0] w_mem_rd;
  logic [DATA_WIDTH-1:0] w_fwd_rd;
  logic                  w_hit;

  assign w_accept = hsel_i & hready_i &
                    ((htrans_i == HTRANS_NONSEQ) || (htrans_i == HTRANS_SEQ));
  assign w_idx    = haddr_i[ADDR_WIDTH-1:LANE_W];
  assign w_off    = haddr_i[LANE_W-1:0];
  assign w_legal  = is_legal(hsize_i, w_off, w_idx);
  assign w_strb   = lane_strobe(hsize_i, w_off);
  assign w_rd_idx = (r_state == ST_RWAIT) ? r_idx[MEM_AW-1:0] : w_idx[MEM_AW-1:0];
  assign w_hit    = r_wr_pend && (r_idx == w_idx);

  ahb_sram_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_DEPTH  (MEM_DEPTH),
    .AW         (MEM_AW)
  ) u_array (
    .i_clk   (hclk),
    .i_we    (r_wr_pend),
    .i_waddr (r_idx[MEM_AW-1:0]),
    .i_wstrb (r_strb),
    .i_wdata (hwdata_i),
    .i_raddr (w_rd_idx),
    .o_rdata (w_mem_rd)
  );

  // Zero-wait reads see a write committing on the same edge
  always_comb begin
    w_fwd_rd = w_mem_rd;
    for (int b = 0; b < NB; b++) begin
      w_fwd_rd[8*b +: 8] = (w_hit && r_strb[b]) ? hwdata_i[8*b +: 8] : w_mem_rd[8*b +: 8];
    end
  end

  // Transfer FSM with registered bus responses
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= 3'd0;
      r_wr_pend <= 1'b0;
      r_idx     <= '0;
      r_strb    <= '0;
      r_hready  <= 1'b1;
      r_hresp   <= HRESP_OKAY;
      r_hrdata  <= '0;
    end else begin
      r_wr_pend <= 1'b0;
      r_hrdata  <= '0;
      case (r_state)
        ST_IDLE, ST_ERR2: begin
          r_state  <= ST_IDLE;
          r_hready <= 1'b1;
          r_hresp  <= HRESP_OKAY;
          if (w_accept) begin
            r_idx  <= w_idx;
            r_strb <= w_strb;
            if (!w_legal) begin
              r_state  <= ST_ERR1;
              r_hready <= 1'b0;
              r_hresp  <= HRESP_ERROR;
            end else if (hwrite_i) begin
              r_wr_pend <= 1'b1;
            end else if (RD_WAIT == 0) begin
              r_hrdata <= w_fwd_rd;
            end else begin
              r_state  <= ST_RWAIT;
              r_cnt    <= 3'(RD_WAIT);
              r_hready <= 1'b0;
            end
          end
        end
        ST_RWAIT: begin
          if (r_cnt == 3'd1) begin
            r_state  <= ST_IDLE;
            r_hready <= 1'b1;
            r_hrdata <= w_mem_rd;
          end else begin
            r_cnt <= r_cnt - 3'd1;
          end
        end
        ST_ERR1: begin
          r_state  <= ST_ERR2;
          r_hready <= 1'b1;
          r_hresp  <= HRESP_ERROR;
        end
        default: begin
          r_state  <= ST_IDLE;
          r_hready <= 1'b1;
          r_hresp  <= HRESP_OKAY;
        end
      endcase
    end
  end

  assign hready_o = r_hready;
  assign hresp_o  = r_hresp;
  assign hrdata_o = r_hrdata;

endmodule

// File: tb/tb_ahb_sram_slave_p.sv
// Directed bench: a 32-bit slave with two read wait states and a 64-bit
// zero-wait slave, both 256 words deep, driven as an AHB master would.
module tb_ahb_sram_slave_p;
  import ahb_pkg::*;

  int errors = 0;
  int checks = 0;

  logic hclk = 1'b0;
  logic hreset = 1'b1;
  always #5 hclk = ~hclk;

  logic        a_hsel = 1'b0, a_hwrite = 1'b0;
  logic [1:0]  a_htrans = HTRANS_IDLE;
  logic [2:0]  a_hsize = HSIZE_BYTE;
  logic [15:0] a_haddr = 16'h0;
  logic [31:0] a_hwdata = 32'h0;
  logic        a_hready_i, a_hready;
  logic [1:0]  a_hresp;
  logic [31:0] a_hrdata;

  logic        b_hsel = 1'b0, b_hwrite = 1'b0;
  logic [1:0]  b_htrans = HTRANS_IDLE;
  logic [2:0]  b_hsize = HSIZE_BYTE;
  logic [15:0] b_haddr = 16'h0;
  logic [63:0] b_hwdata = 64'h0;
  logic        b_hready_i, b_hready;
  logic [1:0]  b_hresp;
  logic [63:0] b_hrdata;

  // Single-slave bus: HREADY seen by the slave is its own HREADYOUT
  assign a_hready_i = a_hready;
  assign b_hready_i = b_hready;

  ahb_sram_slave_p #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .MEM_DEPTH(256), .RD_WAIT(2)) dut_a (
    .hclk(hclk), .hreset(hreset), .hsel_i(a_hsel), .hready_i(a_hready_i),
    .htrans_i(a_htrans), .hsize_i(a_hsize), .hwrite_i(a_hwrite), .haddr_i(a_haddr),
    .hwdata_i(a_hwdata), .hready_o(a_hready), .hresp_o(a_hresp), .hrdata_o(a_hrdata)
  );

  ahb_sram_slave_p #(.ADDR_WIDTH(16), .DATA_WIDTH(64), .MEM_DEPTH(256), .RD_WAIT(0)) dut_b (
    .hclk(hclk), .hreset(hreset), .hsel_i(b_hsel), .hready_i(b_hready_i),
    .htrans_i(b_htrans), .hsize_i(b_hsize), .hwrite_i(b_hwrite), .haddr_i(b_haddr),
    .hwdata_i(b_hwdata), .hready_o(b_hready), .hresp_o(b_hresp), .hrdata_o(b_hrdata)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic exp_a(input string tag, input logic rdy, input logic [1:0] resp, input logic [31:0] rd);
    check({tag, ".hready"}, {63'd0, a_hready}, {63'd0, rdy});
    check({tag, ".hresp"},  {62'd0, a_hresp},  {62'd0, resp});
    check({tag, ".hrdata"}, {32'd0, a_hrdata}, {32'd0, rd});
  endtask

  task automatic exp_b(input string tag, input logic rdy, input logic [1:0] resp, input logic [63:0] rd);
    check({tag, ".hready"}, {63'd0, b_hready}, {63'd0, rdy});
    check({tag, ".hresp"},  {62'd0, b_hresp},  {62'd0, resp});
    check({tag, ".hrdata"}, b_hrdata, rd);
  endtask

  task automatic step_a(input logic sel, input logic [1:0] tr, input logic wr,
                        input logic [2:0] sz, input logic [15:0] ad, input logic [31:0] wd);
    @(posedge hclk);
    #1;
    a_hsel = sel; a_htrans = tr; a_hwrite = wr; a_hsize = sz; a_haddr = ad; a_hwdata = wd;
  endtask

  task automatic idle_a(input logic [31:0] wd);
    step_a(1'b0, HTRANS_IDLE, 1'b0, HSIZE_BYTE, 16'h0, wd);
  endtask

  task automatic step_b(input logic sel, input logic [1:0] tr, input logic wr,
                        input logic [2:0] sz, input logic [15:0] ad, input logic [63:0] wd);
    @(posedge hclk);
    #1;
    b_hsel = sel; b_htrans = tr; b_hwrite = wr; b_hsize = sz; b_haddr = ad; b_hwdata = wd;
  endtask

  task automatic idle_b(input logic [63:0] wd);
    step_b(1'b0, HTRANS_IDLE, 1'b0, HSIZE_BYTE, 16'h0, wd);
  endtask

  initial begin
    repeat (2) @(posedge hclk);
    #1;
    exp_a("reset_held", 1'b1, HRESP_OKAY, 32'h0);
    hreset = 1'b0;
    idle_a(32'h0);
    exp_a("reset_rel", 1'b1, HRESP_OKAY, 32'h0);

    // Word write then read with two wait states
    step_a(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 16'h0010, 32'h0);
    exp_a("wr10_addr", 1'b1, HRESP_OKAY, 32'h0);
    step_a(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 16'h0010, 32'hDEADBEEF);
    exp_a("wr10_data", 1'b1, HRESP_OKAY, 32'h0);
    idle_a(32'h0);
    exp_a("rd10_w1", 1'b0, HRESP_OKAY, 32'h0);
    idle_a(32'h0);
    exp_a("rd10_w2", 1'b0, HRESP_OKAY, 32'h0);
    idle_a(32'h0);
    exp_a("rd10_done", 1'b1, HRESP_OKAY, 32'hDEADBEEF);

    // Sub-word writes with junk in the unselected lanes
    step_a(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_BYTE, 16'h0020, 32'h0);
    exp_a("b20_addr", 1'b1, HRESP_OKAY, 32'h0);
    step_a(1'b1, HTRANS_SEQ, 1'b1, HSIZE_BYTE, 16'h0021, 32'hAAAAAA11);
    step_a(1'b1, HTRANS_SEQ, 1'b1, HSIZE_HALF, 16'h0022, 32'hBBBB22BB);
    step_a(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 16'h0020, 32'h4433CCCC);
    exp_a("h22_data", 1'b1, HRESP_OKAY, 32'h0);
    idle_a(32'h0);
    idle_a(32'h0);
    exp_a("rd20_w2", 1'b0, HRESP_OKAY, 32'h0);
    idle_a(32'h0);
    exp_a("rd20_done", 1'b1, HRESP_OKAY, 32'h44332211);

    // Unaligned half -> ERROR; NONSEQ read issued during ERR2
    step_a(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 16'h0000, 32'h0);
    step_a(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_HALF, 16'h0001, 32'h12345678);
    exp_a("unal_addr", 1'b1, HRESP_OKAY, 32'h0);
    idle_a(32'hFFFFFFFF);
    exp_a("unal_err1", 1'b0, HRESP_ERROR, 32'h0);
    step_a(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 16'h0000, 32'hFFFFFFFF);
    exp_a("unal_err2", 1'b1, HRESP_ERROR, 32'h0);
    idle_a(32'h0);
    exp_a("rd0_w1", 1'b0, HRESP_OKAY, 32'h0);
    idle_a(32'h0);
    idle_a(32'h0);
    exp_a("rd0_done", 1'b1, HRESP_OKAY, 32'h12345678);

    // Word index == MEM_DEPTH (aliases word 0 if truncated)
    step_a(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 16'h0400, 32'h0);
    idle_a(32'hCAFEF00D);
    exp_a("oor_err1", 1'b0, HRESP_ERROR, 32'h0);
    idle_a(32'h0);
    exp_a("oor_err2", 1'b1, HRESP_ERROR, 32'h0);
    idle_a(32'h0);
    exp_a("oor_after", 1'b1, HRESP_OKAY, 32'h0);

    // Doubleword size on a 32-bit slave
    step_a(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_DWORD, 16'h0008, 32'h0);
    idle_a(32'h0);
    exp_a("sz3_err1", 1'b0, HRESP_ERROR, 32'h0);
    idle_a(32'h0);
    exp_a("sz3_err2", 1'b1, HRESP_ERROR, 32'h0);

    // BUSY, deselected and IDLE cycles have no side effects
    step_a(1'b1, HTRANS_BUSY, 1'b1, HSIZE_WORD, 16'h0000, 32'h0);
    exp_a("busy", 1'b1, HRESP_OKAY, 32'h0);
    step_a(1'b0, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 16'h0000, 32'hFFFFFFFF);
    exp_a("nosel", 1'b1, HRESP_OKAY, 32'h0);
    step_a(1'b1, HTRANS_IDLE, 1'b1, HSIZE_WORD, 16'h0000, 32'hFFFFFFFF);
    exp_a("idle", 1'b1, HRESP_OKAY, 32'h0);
    step_a(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 16'h0000, 32'hFFFFFFFF);
    idle_a(32'h0);
    idle_a(32'h0);
    idle_a(32'h0);
    exp_a("rd0_again", 1'b1, HRESP_OKAY, 32'h12345678);

    // Asynchronous reset during RWAIT; memory survives
    step_a(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 16'h0010, 32'h0);
    idle_a(32'h0);
    exp_a("pre_rst", 1'b0, HRESP_OKAY, 32'h0);
    hreset = 1'b1;
    #1;
    exp_a("rst_rwait", 1'b1, HRESP_OKAY, 32'h0);
    idle_a(32'h0);
    hreset = 1'b0;
    step_a(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 16'h0010, 32'h0);
    exp_a("post_rst_addr", 1'b1, HRESP_OKAY, 32'h0);
    idle_a(32'h0);
    exp_a("post_rst_w1", 1'b0, HRESP_OKAY, 32'h0);
    idle_a(32'h0);
    idle_a(32'h0);
    exp_a("post_rst_rd", 1'b1, HRESP_OKAY, 32'hDEADBEEF);

    // 64-bit zero-wait slave: back-to-back write/read forwarding
    step_b(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_DWORD, 16'h0008, 64'h0);
    exp_b("b_wr_addr", 1'b1, HRESP_OKAY, 64'h0);
    step_b(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_DWORD, 16'h0008, 64'h0123456789ABCDEF);
    exp_b("b_wr_data", 1'b1, HRESP_OKAY, 64'h0);
    step_b(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_BYTE, 16'h000F, 64'h0);
    exp_b("b_rd", 1'b1, HRESP_OKAY, 64'h0123456789ABCDEF);
    step_b(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_DWORD, 16'h0008, 64'hEE11223344556677);
    exp_b("b_byte_data", 1'b1, HRESP_OKAY, 64'h0);
    step_b(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_DWORD, 16'h0004, 64'h0);
    exp_b("b_rd_lane7", 1'b1, HRESP_OKAY, 64'hEE23456789ABCDEF);
    idle_b(64'h0);
    exp_b("b_err1", 1'b0, HRESP_ERROR, 64'h0);
    idle_b(64'h0);
    exp_b("b_err2", 1'b1, HRESP_ERROR, 64'h0);
    idle_b(64'h0);
    exp_b("b_after", 1'b1, HRESP_OKAY, 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ahb_sram_slave_p.md
Name: ahb_sram_slave_p

Overview:
Parametrised AHB-Lite SRAM slave: the next generation of the team's fixed 32-bit, 16K-word AHB memory slave. It adds configurable data width, memory depth and read wait states. It adds a two-cycle ERROR response for illegal transfers, and byte-lane write strobes generalised to any DATA_WIDTH. It sits behind the AHB decoder/mux as a generic on-chip RAM endpoint.

Parameters:
ADDR_WIDTH, 16, byte address width of haddr_i
DATA_WIDTH, 32, hwdata/hrdata width; legal values 32 or 64
MEM_DEPTH, 16384, number of DATA_WIDTH-bit words; must be ≤ 2**(ADDR_WIDTH-log2(DATA_WIDTH/8))
RD_WAIT, 1, read wait states inserted in the data phase (0..7)

Ports:
hclk  in  1  bus clock, all logic on rising edge
hreset  in  1  asynchronous, active-high reset
hsel_i  in  1  slave select from decoder
hready_i  in  1  bus-level HREADY (previous transfer complete)
htrans_i  in  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11
hsize_i  in  3  transfer size code
hwrite_i  in  1  1=write
haddr_i  in  ADDR_WIDTH  byte address
hwdata_i  in  DATA_WIDTH  write data (data phase)
hready_o  out  1  slave ready
hresp_o  out  2  OKAY=00, ERROR=01
hrdata_o  out  DATA_WIDTH  read data

Behaviour:
- Reset (async assert, sync release): FSM=IDLE, hready_o=1, hresp_o=00, hrdata_o=0, all pipeline registers cleared; memory contents not reset. Reset mid-transfer abandons it with no memory update.
- Address phase accepted when hsel_i & hready_i & htrans_i[1]. BUSY and IDLE produce a zero-wait OKAY data phase with no side effects.
- On acceptance, register: write flag, word index = haddr_i[ADDR_WIDTH-1:log2(DW/8)], byte strobes (DW/8 bits), byte offset and legality.
- Illegal transfer, if any of:
  - hsize_i > log2(DATA_WIDTH/8);
  - address not aligned to hsize_i;
  - word index ≥ MEM_DEPTH.
- Strobes: the 2**hsize_i lanes starting at lane haddr_i[log2(DW/8)-1:0].
- FSM states: IDLE, RWAIT, ERR1, ERR2.
  - IDLE: accepted legal write → data phase completes this cycle, hready_o=1, and memory lanes with strobe=1 take hwdata_i at end of data phase. Accepted legal read with RD_WAIT=0 → data phase hready_o=1, hrdata_o=mem[idx]. Accepted legal read with RD_WAIT>0 → RWAIT, counter loaded with RD_WAIT.
  - RWAIT: hready_o=0, hrdata_o=0. The counter decrements each cycle. The data phase ends (hready_o=1, hrdata_o=mem[idx]) in the cycle after the counter hits 1. Total read data phase = RD_WAIT+1 cycles.
  - Illegal accepted transfer → ERR1: hready_o=0, hresp_o=01. Next cycle ERR2: hready_o=1, hresp_o=01. Then IDLE. No memory write.
- New address phases are evaluated only when hready_i=1. The transfer presented during ERR2 or the final read cycle is accepted normally, which gives back-to-back pipelining. The master may also issue IDLE in ERR2; no extra handling is required.
- Write followed immediately by a read of the same word: the read returns the newly written data, because the write commits at the edge that starts the read data phase.
- hrdata_o=0 in every cycle except a completing OKAY read data phase.
- Full read data word is returned regardless of size; the master selects lanes.

Decomposition:
- Package ahb_pkg: HTRANS_* and HRESP_OKAY/HRESP_ERROR constants, HSIZE_* codes, FSM state enum.
- Sub-module ahb_sram_array: MEM_DEPTH×DATA_WIDTH memory, one write port with per-byte enable, asynchronous read port.
- FSM, decode and strobe logic stay in the top module.

Test Plan:
- Reset with hreset=1 while in RWAIT → hready_o=1, hresp_o=00, hrdata_o=0 immediately; next legal read returns pre-reset memory contents.
- DW=32, RD_WAIT=2: word write 0xDEADBEEF to 0x0010, then read 0x0010 → read data phase shows hready_o=0,0,1 and hrdata_o=0xDEADBEEF on the third cycle.
- Byte writes 0x11@0x20, 0x22@0x21, half 0x4433@0x22, then word read 0x20 → 0x44332211.
- DW=64, RD_WAIT=0: doubleword write 0x0123456789ABCDEF@0x08, back-to-back read @0x08 → zero-wait, hrdata_o=0x0123456789ABCDEF.
- Unaligned half at 0x0001 → hready_o/hresp_o = 0/01, then 1/01; memory unchanged. Repeat with word index = MEM_DEPTH and with hsize=011 at DW=32 → same ERROR pattern.
- BUSY/IDLE and hsel_i=0 cycles between transfers → hready_o=1, hresp_o=00, no memory change; NONSEQ issued in ERR2 is accepted and completes correctly.
